// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, channel FSM states
// and the byte-strobe merge helper used on write commit.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam int MAX_DW = 64;

  // Operates at the widest supported bus; narrower callers zero-extend and truncate.
  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0]   old_val,
    input logic [MAX_DW-1:0]   new_val,
    input logic [MAX_DW/8-1:0] strb
  );
    logic [MAX_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < MAX_DW / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite slave bundle (AW/W/B/AR/R channels); the master modport is the
// interconnect side, the slave modport is the register bank side.
interface axil_reg_bank_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_decode.sv
// Byte address -> register index, with range and read-only classification.
// Purely combinational; one instance per AXI channel.
module axil_reg_decode
  import axil_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter int                  ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter int                  REG_IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [REG_IW-1:0]     idx,
  output logic                  in_range,
  output logic                  is_ro
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int RO_W  = 1 << IDX_W;
  // Mask widened to the full index space so out-of-range indices read as RW (and fail the range check).
  localparam logic [RO_W-1:0] RO_EXT = RO_W'(RO_MASK);

  logic [IDX_W-1:0] full_idx;
  logic             unused_offset;

  assign full_idx      = addr[ADDR_WIDTH-1:OFF_W];
  assign unused_offset = ^addr[OFF_W-1:0];

  assign idx      = REG_IW'(full_idx);
  assign in_range = (32'(full_idx) < NUM_REGS);
  assign is_ro    = RO_EXT[full_idx];

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite control/status register bank: write commits on the edge completing AW+W, read data one cycle
// after AR; B/R held until BREADY/RREADY, one outstanding transaction per channel.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_reg_bank_if.slave                 s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int REG_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] stat [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_map
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    assign stat[g] = reg_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_state_n;
  logic                  aw_held, aw_held_n, w_held, w_held_n;
  logic                  aw_rdy, aw_rdy_n, w_rdy, w_rdy_n;
  logic                  bvalid, bvalid_n;
  resp_t                 bresp, bresp_n;
  logic                  commit;
  logic                  aw_hs, w_hs, aw_have, w_have;
  logic [ADDR_WIDTH-1:0] aw_addr_q, w_addr;
  logic [DATA_WIDTH-1:0] w_dat_q, w_dat;
  logic [STRB_W-1:0]     w_strb_q, w_strb;
  logic [REG_IW-1:0]     w_idx;
  logic                  w_in_range, w_is_ro, w_ok;
  logic [MAX_DW-1:0]     merged;

  assign aw_hs   = s_axi.awvalid && aw_rdy;
  assign w_hs    = s_axi.wvalid && w_rdy;
  assign aw_have = aw_held || aw_hs;
  assign w_have  = w_held || w_hs;

  // A beat arriving this cycle is used directly so the commit does not wait an extra edge.
  assign w_addr = aw_hs ? s_axi.awaddr : aw_addr_q;
  assign w_dat  = w_hs ? s_axi.wdata : w_dat_q;
  assign w_strb = w_hs ? s_axi.wstrb : w_strb_q;

  axil_reg_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RO_MASK    (RO_MASK),
    .REG_IW     (REG_IW)
  ) u_w_dec (
    .addr     (w_addr),
    .idx      (w_idx),
    .in_range (w_in_range),
    .is_ro    (w_is_ro)
  );

  assign w_ok   = w_in_range && !w_is_ro;
  assign merged = strb_merge(MAX_DW'(regs[w_idx]), MAX_DW'(w_dat), (MAX_DW/8)'(w_strb));

  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_rdy_n  = aw_rdy;
    w_rdy_n   = w_rdy;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    commit    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_have && w_have) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          aw_rdy_n  = 1'b0;
          w_rdy_n   = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = w_ok ? OKAY : SLVERR;
        end else begin
          aw_held_n = aw_have;
          w_held_n  = w_have;
          aw_rdy_n  = !aw_have;
          w_rdy_n   = !w_have;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
          aw_rdy_n  = 1'b1;
          w_rdy_n   = 1'b1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_rdy  <= 1'b0;
      w_rdy   <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      w_state <= w_state_n;
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      aw_rdy  <= aw_rdy_n;
      w_rdy   <= w_rdy_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_addr_q <= '0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi.awaddr;
      if (w_hs) begin
        w_dat_q  <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      wr_pulse <= '0;
      if (commit && w_ok) begin
        regs[w_idx] <= merged[DATA_WIDTH-1:0];
        wr_pulse    <= NUM_REGS'(1) << w_idx;
      end
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_n;
  logic                  ar_rdy, ar_rdy_n;
  logic                  rvalid, rvalid_n;
  resp_t                 rresp, rresp_n;
  logic [DATA_WIDTH-1:0] rdata, rdata_n, r_sel;
  logic                  ar_hs;
  logic [REG_IW-1:0]     r_idx;
  logic                  r_in_range, r_is_ro;

  assign ar_hs = s_axi.arvalid && ar_rdy;

  axil_reg_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RO_MASK    (RO_MASK),
    .REG_IW     (REG_IW)
  ) u_r_dec (
    .addr     (s_axi.araddr),
    .idx      (r_idx),
    .in_range (r_in_range),
    .is_ro    (r_is_ro)
  );

  // regs is sampled before any same-edge commit lands, so a colliding read sees the old value.
  always_comb begin
    r_sel = '0;
    if (r_in_range) r_sel = r_is_ro ? stat[r_idx] : regs[r_idx];
  end

  always_comb begin
    r_state_n = r_state;
    ar_rdy_n  = ar_rdy;
    rvalid_n  = rvalid;
    rresp_n   = rresp;
    rdata_n   = rdata;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_n = R_DATA;
          ar_rdy_n  = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = r_sel;
          rresp_n   = r_in_range ? OKAY : SLVERR;
        end else begin
          ar_rdy_n = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
          ar_rdy_n  = 1'b1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= OKAY;
      rdata   <= '0;
    end else begin
      r_state <= r_state_n;
      ar_rdy  <= ar_rdy_n;
      rvalid  <= rvalid_n;
      rresp   <= rresp_n;
      rdata   <= rdata_n;
    end
  end

  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rresp   = rresp;
  assign s_axi.rdata   = rdata;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, merged};

endmodule
